// File: rtl/stopwatch_pkg.sv
// Shared types and default constants for the stopwatch control sequencer.
// Optional long-press clear is enabled by defining STOPWATCH_LONGPRESS_CLEAR_EN.
package stopwatch_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      RUN   = 2'd1,
      PAUSE = 2'd2
   } sw_state_t;

   localparam int SAMPLE_DIV_DEF        = 62500;
   localparam int DEBOUNCE_SAMPLES_DEF  = 20;
   localparam int TICK_DIV_DEF          = 500000;
   localparam int LONGPRESS_SAMPLES_DEF = 1600;

   // Bits needed for a counter running 0..n-1, never less than one.
   function automatic int cnt_width(input int n);
      return (n > 2) ? $clog2(n) : 1;
   endfunction

   localparam int SAMPLE_W_DEF    = cnt_width(SAMPLE_DIV_DEF);
   localparam int DEBOUNCE_W_DEF  = cnt_width(DEBOUNCE_SAMPLES_DEF);
   localparam int TICK_W_DEF      = cnt_width(TICK_DIV_DEF);
   localparam int LONGPRESS_W_DEF = cnt_width(LONGPRESS_SAMPLES_DEF);

endpackage

// File: rtl/stopwatch_ctrl_key_debounce.sv
// Key conditioner: 2-flop synchroniser, strobe-sampled debouncer and press pulse.
// A new level needs one changed sample followed by DEBOUNCE_SAMPLES equal samples.
module key_debounce
   import stopwatch_pkg::*;
#(
   parameter int DEBOUNCE_SAMPLES = DEBOUNCE_SAMPLES_DEF
) (
   input  logic clk,
   input  logic rst,
   input  logic strobe,
   input  logic key,
   output logic level,
   output logic press
);

   localparam int CW = cnt_width(DEBOUNCE_SAMPLES);
   localparam logic [CW-1:0] STABLE_LAST = CW'(DEBOUNCE_SAMPLES - 1);

   logic            sync1_r;
   logic            sync2_r;
   logic            candidate_r;
   logic            level_d_r;
   logic [CW-1:0]   stable_cnt_r;

   // Bring the raw key into the clock domain
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         sync1_r <= 1'b1;
         sync2_r <= 1'b1;
      end else begin
         sync1_r <= key;
         sync2_r <= sync1_r;
      end
   end

   // Candidate tracking and level acceptance on each sample strobe
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         candidate_r  <= 1'b1;
         stable_cnt_r <= {CW{1'b0}};
         level        <= 1'b1;
         level_d_r    <= 1'b1;
      end else begin
         level_d_r <= level;
         if (strobe) begin
            if (sync2_r != candidate_r) begin
               candidate_r  <= sync2_r;
               stable_cnt_r <= {CW{1'b0}};
            end else if (stable_cnt_r == STABLE_LAST) begin
               level        <= candidate_r;
               stable_cnt_r <= {CW{1'b0}};
            end else begin
               stable_cnt_r <= stable_cnt_r + CW'(1);
            end
         end
      end
   end

   assign press = level_d_r & ~level;

endmodule

// File: rtl/stopwatch_ctrl.sv
// Stopwatch control sequencer: key debouncing, IDLE/RUN/PAUSE FSM, 10 ms tick, clear/freeze.
// Define STOPWATCH_LONGPRESS_CLEAR_EN for the long-hold-in-PAUSE clear.
module stopwatch_ctrl
   import stopwatch_pkg::*;
#(
   parameter int SAMPLE_DIV       = SAMPLE_DIV_DEF,
   parameter int DEBOUNCE_SAMPLES = DEBOUNCE_SAMPLES_DEF,
   parameter int TICK_DIV         = TICK_DIV_DEF
`ifdef STOPWATCH_LONGPRESS_CLEAR_EN
   , parameter int LONGPRESS_SAMPLES = LONGPRESS_SAMPLES_DEF
`endif
) (
   input  logic clk,
   input  logic rst,
   input  logic key_reset,
   input  logic key_start_pause,
   input  logic key_display_stop,
   output logic count_tick,
   output logic count_clear,
   output logic display_load,
   output logic led_run,
   output logic led_pause,
   output logic led_freeze,
   output logic led_key
);

   localparam int SW = cnt_width(SAMPLE_DIV);
   localparam int TW = cnt_width(TICK_DIV);
   localparam logic [SW-1:0] SAMPLE_LAST = SW'(SAMPLE_DIV - 1);
   localparam logic [TW-1:0] TICK_LAST   = TW'(TICK_DIV - 1);

   logic [SW-1:0] sample_cnt_r;
   logic          strobe_s;
   logic          reset_level_unused;
   logic          display_level_unused;
   logic          start_level_s;
   logic          reset_press_s;
   logic          start_press_s;
   logic          display_press_s;
   logic          clear_ev_s;
   logic          start_ev_s;
   sw_state_t     state_r;
   sw_state_t     state_nx_s;
   logic          freeze_r;
   logic          freeze_nx_s;
   logic [TW-1:0] tick_cnt_r;
   logic [TW-1:0] tick_nx_s;
   logic          tick_fire_s;
   logic          clear_nx_s;

   // Free-running key sample strobe divider
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         sample_cnt_r <= {SW{1'b0}};
      end else if (strobe_s) begin
         sample_cnt_r <= {SW{1'b0}};
      end else begin
         sample_cnt_r <= sample_cnt_r + SW'(1);
      end
   end

   assign strobe_s = (sample_cnt_r == SAMPLE_LAST);

   key_debounce #(.DEBOUNCE_SAMPLES(DEBOUNCE_SAMPLES)) u_key_reset (
      .clk(clk), .rst(rst), .strobe(strobe_s), .key(key_reset),
      .level(reset_level_unused), .press(reset_press_s)
   );

   key_debounce #(.DEBOUNCE_SAMPLES(DEBOUNCE_SAMPLES)) u_key_start (
      .clk(clk), .rst(rst), .strobe(strobe_s), .key(key_start_pause),
      .level(start_level_s), .press(start_press_s)
   );

   key_debounce #(.DEBOUNCE_SAMPLES(DEBOUNCE_SAMPLES)) u_key_display (
      .clk(clk), .rst(rst), .strobe(strobe_s), .key(key_display_stop),
      .level(display_level_unused), .press(display_press_s)
   );

`ifdef STOPWATCH_LONGPRESS_CLEAR_EN
   localparam int LW = cnt_width(LONGPRESS_SAMPLES);
   localparam logic [LW-1:0] LP_LAST = LW'(LONGPRESS_SAMPLES - 1);

   logic          lp_armed_r;
   logic [LW-1:0] lp_cnt_r;
   logic          long_ev_s;
   logic          resume_ev_s;

   // A start press in PAUSE is held back until release or a long hold
   assign long_ev_s   = lp_armed_r && strobe_s && !start_level_s && (lp_cnt_r == LP_LAST);
   assign resume_ev_s = lp_armed_r && start_level_s;
   assign clear_ev_s  = reset_press_s || long_ev_s;
   assign start_ev_s  = (start_press_s && (state_r != PAUSE)) || resume_ev_s;

   // Long-press hold timer
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         lp_armed_r <= 1'b0;
         lp_cnt_r   <= {LW{1'b0}};
      end else if (clear_ev_s || resume_ev_s) begin
         lp_armed_r <= 1'b0;
         lp_cnt_r   <= {LW{1'b0}};
      end else if (start_press_s && (state_r == PAUSE)) begin
         lp_armed_r <= 1'b1;
         lp_cnt_r   <= {LW{1'b0}};
      end else if (lp_armed_r && strobe_s) begin
         lp_cnt_r   <= lp_cnt_r + LW'(1);
      end else begin
         lp_cnt_r   <= lp_cnt_r;
      end
   end
`else
   assign clear_ev_s = reset_press_s;
   assign start_ev_s = start_press_s;
`endif

   // Next state, freeze, prescaler and output pulses
   always_comb begin
      state_nx_s  = state_r;
      freeze_nx_s = freeze_r;
      tick_nx_s   = tick_cnt_r;
      clear_nx_s  = 1'b0;
      case (state_r)
         RUN:     tick_nx_s = (tick_cnt_r == TICK_LAST) ? {TW{1'b0}} : tick_cnt_r + TW'(1);
         PAUSE:   tick_nx_s = tick_cnt_r;
         default: tick_nx_s = {TW{1'b0}};
      endcase
      if (clear_ev_s) begin
         state_nx_s  = IDLE;
         freeze_nx_s = 1'b0;
         tick_nx_s   = {TW{1'b0}};
         clear_nx_s  = 1'b1;
      end else begin
         if (start_ev_s) begin
            case (state_r)
               IDLE:    state_nx_s = RUN;
               RUN:     state_nx_s = PAUSE;
               PAUSE:   state_nx_s = RUN;
               default: state_nx_s = IDLE;
            endcase
         end else begin
            state_nx_s = state_r;
         end
         if (display_press_s) begin
            freeze_nx_s = ~freeze_r;
         end else begin
            freeze_nx_s = freeze_r;
         end
      end
      // Registered so the tick lands in the cycle where the prescaler shows its last value
      tick_fire_s = (state_nx_s == RUN) && (tick_nx_s == TICK_LAST);
   end

   // State and registered outputs
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_r      <= IDLE;
         freeze_r     <= 1'b0;
         tick_cnt_r   <= {TW{1'b0}};
         count_tick   <= 1'b0;
         count_clear  <= 1'b0;
         display_load <= 1'b1;
         led_run      <= 1'b0;
         led_pause    <= 1'b0;
         led_freeze   <= 1'b0;
         led_key      <= 1'b0;
      end else begin
         state_r      <= state_nx_s;
         freeze_r     <= freeze_nx_s;
         tick_cnt_r   <= tick_nx_s;
         count_tick   <= tick_fire_s;
         count_clear  <= clear_nx_s;
         display_load <= ~freeze_nx_s;
         led_run      <= (state_nx_s == RUN);
         led_pause    <= (state_nx_s == PAUSE);
         led_freeze   <= freeze_nx_s;
         led_key      <= ~start_level_s;
      end
   end

endmodule

// File: tb/tb_stopwatch_ctrl.sv
// Self-checking bench for stopwatch_ctrl: directed scenarios plus random key activity,
// every cycle compared against a behavioural model of the key/FSM/tick rules.
module tb_stopwatch_ctrl;

   localparam int SD = 4;
   localparam int DB = 3;
   localparam int TD = 5;

   logic clk = 1'b0;
   logic rst = 1'b1;
   logic key_reset = 1'b1;
   logic key_start_pause = 1'b1;
   logic key_display_stop = 1'b1;
   logic count_tick, count_clear, display_load;
   logic led_run, led_pause, led_freeze, led_key;

   always #5 clk = ~clk;

   stopwatch_ctrl #(.SAMPLE_DIV(SD), .DEBOUNCE_SAMPLES(DB), .TICK_DIV(TD)) dut (
      .clk(clk), .rst(rst),
      .key_reset(key_reset), .key_start_pause(key_start_pause), .key_display_stop(key_display_stop),
      .count_tick(count_tick), .count_clear(count_clear), .display_load(display_load),
      .led_run(led_run), .led_pause(led_pause), .led_freeze(led_freeze), .led_key(led_key)
   );

   int n_pass = 0;
   int n_fail = 0;
   int n_total = 0;
   int seen_ticks = 0;
   int seen_clears = 0;

   // Model: keys indexed 0 = reset, 1 = start, 2 = display; state 0 idle, 1 run, 2 pause
   int       m_cyc, m_phase, m_state;
   bit       m_freeze, m_clear, m_tick, m_led_key;
   bit [2:0] m_d0, m_d1, m_d2;
   bit       m_lvl [3];
   bit       m_last[3];
   bit       m_pend[3];
   int       m_run [3];

   task automatic chk(input string tag, input logic got, input logic exp);
      n_total++;
      assert (got === exp) n_pass++;
      else begin
         n_fail++;
         $error("FAIL %s: got %b expected %b", tag, got, exp);
      end
   endtask

   task automatic chk_int(input string tag, input int got, input int exp);
      n_total++;
      assert (got === exp) n_pass++;
      else begin
         n_fail++;
         $error("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask

   task automatic model_reset();
      m_cyc = 0; m_phase = 0; m_state = 0;
      m_freeze = 1'b0; m_clear = 1'b0; m_tick = 1'b0; m_led_key = 1'b0;
      m_d0 = 3'b111; m_d1 = 3'b111; m_d2 = 3'b111;
      for (int i = 0; i < 3; i++) begin
         m_lvl[i] = 1'b1; m_last[i] = 1'b1; m_pend[i] = 1'b0; m_run[i] = 0;
      end
   endtask

   // One clock edge of the reference behaviour
   task automatic model_edge();
      bit [2:0] raw;
      bit       s;
      raw = {key_display_stop, key_start_pause, key_reset};
      m_cyc++;
      m_clear = 1'b0;
      if (m_state == 1) m_phase = (m_phase + 1) % TD;
      else if (m_state == 0) m_phase = 0;
      if (m_pend[0]) begin
         m_state = 0; m_freeze = 1'b0; m_clear = 1'b1; m_phase = 0;
      end else begin
         if (m_pend[1]) m_state = (m_state == 1) ? 2 : 1;
         if (m_pend[2]) m_freeze = !m_freeze;
      end
      m_tick = (m_state == 1) && (m_phase == TD - 1);
      m_led_key = !m_lvl[1];
      for (int i = 0; i < 3; i++) m_pend[i] = 1'b0;
      m_d2 = m_d1; m_d1 = m_d0; m_d0 = raw;
      if (m_cyc % SD == 0) begin
         for (int i = 0; i < 3; i++) begin
            s = m_d2[i];
            if (s == m_last[i]) m_run[i]++;
            else begin
               m_last[i] = s; m_run[i] = 1;
            end
            if (m_run[i] >= DB + 1 && m_lvl[i] != s) begin
               m_lvl[i] = s;
               m_pend[i] = (s == 1'b0);
            end
         end
      end
   endtask

   task automatic check_all();
      chk("count_tick", count_tick, m_tick);
      chk("count_clear", count_clear, m_clear);
      chk("display_load", display_load, !m_freeze);
      chk("led_run", led_run, m_state == 1);
      chk("led_pause", led_pause, m_state == 2);
      chk("led_freeze", led_freeze, m_freeze);
      chk("led_key", led_key, m_led_key);
   endtask

   task automatic check_reset_values(input string tag);
      chk({tag, "_tick"}, count_tick, 1'b0);
      chk({tag, "_clear"}, count_clear, 1'b0);
      chk({tag, "_display_load"}, display_load, 1'b1);
      chk({tag, "_led_run"}, led_run, 1'b0);
      chk({tag, "_led_pause"}, led_pause, 1'b0);
      chk({tag, "_led_freeze"}, led_freeze, 1'b0);
      chk({tag, "_led_key"}, led_key, 1'b0);
   endtask

   task automatic cyc();
      @(posedge clk);
      model_edge();
      @(negedge clk);
      check_all();
      seen_ticks  += int'(count_tick);
      seen_clears += int'(count_clear);
   endtask

   task automatic hold(input int n);
      repeat (n) cyc();
   endtask

   task automatic wait_state(input string tag, input logic want_run, input logic want_pause);
      int k = 0;
      while (!(led_run === want_run && led_pause === want_pause) && k < 80) begin
         cyc();
         k++;
      end
      chk({tag, "_run"}, led_run, want_run);
      chk({tag, "_pause"}, led_pause, want_pause);
   endtask

   initial begin
      int pause_phase;
      int k;

      model_reset();
      @(negedge clk);
      check_reset_values("reset");
      rst = 1'b0;

      // Bouncing start key never produces a press
      seen_ticks = 0;
      for (int i = 0; i < 40; i++) begin
         key_start_pause = ((i / 3) % 2 == 1);
         cyc();
      end
      key_start_pause = 1'b1;
      hold(30);
      chk("bounce_idle", led_run, 1'b0);
      chk_int("bounce_ticks", seen_ticks, 0);

      // Clean press: RUN, then 4 ticks in the first 20 RUN cycles
      key_start_pause = 1'b0;
      wait_state("press_run", 1'b1, 1'b0);
      seen_ticks = 0;
      hold(19);
      chk_int("run_ticks_20clk", seen_ticks, 4);
      key_start_pause = 1'b1;
      hold(24);
      chk("still_run_after_release", led_run, 1'b1);

      // Pause holds the prescaler phase
      key_start_pause = 1'b0;
      wait_state("pause", 1'b0, 1'b1);
      pause_phase = m_phase;
      key_start_pause = 1'b1;
      seen_ticks = 0;
      hold(100);
      chk_int("pause_no_ticks", seen_ticks, 0);
      key_start_pause = 1'b0;
      wait_state("resume", 1'b1, 1'b0);
      k = 0;
      while (count_tick !== 1'b1 && k < 3 * TD) begin
         cyc();
         k++;
      end
      chk_int("resume_first_tick", k, TD - 1 - pause_phase);
      key_start_pause = 1'b1;
      hold(24);

      // Reset and display pressed together: reset wins, freeze untouched
      key_reset = 1'b0;
      key_display_stop = 1'b0;
      seen_clears = 0;
      hold(30);
      chk_int("prio_clear_pulses", seen_clears, 1);
      chk("prio_idle", led_run, 1'b0);
      chk("prio_freeze", led_freeze, 1'b0);
      chk("prio_display_load", display_load, 1'b1);
      key_reset = 1'b1;
      key_display_stop = 1'b1;
      hold(24);

      // Freeze toggles while ticks continue
      key_start_pause = 1'b0;
      wait_state("freeze_run", 1'b1, 1'b0);
      key_start_pause = 1'b1;
      hold(24);
      seen_ticks = 0;
      key_display_stop = 1'b0;
      hold(30);
      key_display_stop = 1'b1;
      hold(24);
      chk("frozen_led", led_freeze, 1'b1);
      chk("frozen_display_load", display_load, 1'b0);
      chk("frozen_ticking", seen_ticks > 0, 1'b1);
      key_display_stop = 1'b0;
      hold(30);
      key_display_stop = 1'b1;
      hold(24);
      chk("unfrozen_display_load", display_load, 1'b1);

      // Asynchronous reset in the middle of RUN
      chk("pre_rst_run", led_run, 1'b1);
      #2;
      rst = 1'b1;
      #1;
      check_reset_values("async_rst");
      @(posedge clk);
      @(negedge clk);
      check_reset_values("rst_held");
      rst = 1'b0;
      model_reset();
      seen_ticks = 0;
      hold(8);
      chk_int("post_rst_ticks", seen_ticks, 0);

      // Random key activity against the model
      for (int s = 0; s < 40; s++) begin
         key_reset        = ($urandom_range(7) != 0);
         key_start_pause  = ($urandom_range(1) == 1);
         key_display_stop = ($urandom_range(2) != 0);
         hold(int'($urandom_range(40, 1)));
      end

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
